// File: rtl/sqrt_flow_ctrl.sv
// sqrt_flow_ctrl: credit-based flow control around an external, non-resettable
// square-root pipeline. Radicands are issued only when a result slot is
// guaranteed in the output FIFO. After reset, a flush window of PIPE_LATENCY
// cycles discards any stale results still travelling through the pipeline.
//
// Handshake semantics (both sides): a transfer happens in a cycle where
// valid && ready are both 1 at the rising clock edge. valid does not depend
// on ready. Input side: in_valid/in_ready. Output side: out_valid/out_ready.
module sqrt_flow_ctrl #(
  parameter int INPUT_BITS   = 16,
  localparam int OUTPUT_BITS = INPUT_BITS / 2 + INPUT_BITS % 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int PIPE_LATENCY = INPUT_BITS / 2 + INPUT_BITS % 2 + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INPUT_BITS-1:0]           in_radicand,
  output logic                            sq_start,
  output logic [INPUT_BITS-1:0]           sq_radicand,
  input  logic                            sq_data_valid,
  input  logic [OUTPUT_BITS-1:0]          sq_root,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUTPUT_BITS-1:0]          out_root,
  output logic [$clog2(FIFO_DEPTH):0]     credits,
  output logic                            overflow,
  output logic [0:0]                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(PIPE_LATENCY + 2);

  localparam logic [0:0] ST_FLUSH = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]             state;
  logic [LW-1:0]          flush_cnt;
  logic                   flushing;

  logic [OUTPUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   pop;
  logic                   wr_en;
  logic                   wr_ok;

  assign flushing    = (state == ST_FLUSH);
  assign dbg_state   = state;

  assign in_ready    = !flushing && (credits < CW'(FIFO_DEPTH));
  assign sq_start    = in_valid && in_ready;
  assign sq_radicand = in_radicand;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  // Results arriving during the flush window belong to pre-reset issues.
  assign wr_en       = sq_data_valid && !flushing;
  // A full FIFO can still take a write when the head leaves the same cycle.
  assign wr_ok       = wr_en && (!full || pop);
  assign out_root    = out_valid ? mem[rd_ptr] : '0;

  // Flush FSM: hold off issue and ignore results for PIPE_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FLUSH;
      flush_cnt <= LW'(PIPE_LATENCY);
    end else if (state == ST_FLUSH) begin
      if (flush_cnt <= LW'(1)) begin
        state     <= ST_RUN;
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt - LW'(1);
      end
    end
  end

  // Credits track FIFO occupancy plus results still in the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else if (sq_start && !pop) begin
      credits <= credits + CW'(1);
    end else if (pop && !sq_start && credits != '0) begin
      credits <= credits - CW'(1);
    end
  end

  // FIFO storage; contents need no reset because out_root is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= sq_root;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr_ok) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky overflow: a result arrived with nowhere to go and was dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sqrt_flow_ctrl.sv
// Directed bench for sqrt_flow_ctrl with a behavioural, non-resettable sqrt
// pipeline attached and a side door to inject raw result strobes.
module tb_sqrt_flow_ctrl;

  localparam int IB    = 16;
  localparam int OB    = 8;
  localparam int DEPTH = 8;
  localparam int LAT   = 9;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IB-1:0] in_radicand;
  logic          sq_start;
  logic [IB-1:0] sq_radicand;
  logic          sq_data_valid;
  logic [OB-1:0] sq_root;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_root;
  logic [3:0]    credits;
  logic          overflow;
  logic [0:0]    dbg_state;

  logic          force_dv;
  logic [OB-1:0] force_root;

  int n_cmp = 0;
  int n_err = 0;

  sqrt_flow_ctrl #(.INPUT_BITS(IB), .FIFO_DEPTH(DEPTH), .PIPE_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_radicand   (in_radicand),
    .sq_start      (sq_start),
    .sq_radicand   (sq_radicand),
    .sq_data_valid (sq_data_valid),
    .sq_root       (sq_root),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_root      (out_root),
    .credits       (credits),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural sqrt pipeline: LAT cycles from sq_start to sq_data_valid.
  function automatic logic [OB-1:0] isqrt(input logic [IB-1:0] x);
    int r;
    r = 0;
    for (int k = 0; k < 256; k++) begin
      if (k * k <= int'(x)) r = k;
    end
    return OB'(r);
  endfunction

  logic          pv [LAT];
  logic [OB-1:0] pr [LAT];

  always @(posedge clk) begin
    pv[0] <= sq_start;
    pr[0] <= isqrt(sq_radicand);
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
    end
  end

  assign sq_data_valid = pv[LAT-1] | force_dv;
  assign sq_root       = force_dv ? force_root : pr[LAT-1];

  // Driver / checker helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, check the head root, then let it pop.
  task automatic expect_root(input string tag, input logic [OB-1:0] exp);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_root"}, 32'(out_root), 32'(exp));
    tick();
  endtask

  int ready_low;
  int idx;
  int k;
  int seen;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_radicand = '0;
    out_ready   = 1'b0;
    force_dv    = 1'b0;
    force_root  = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_credits",   32'(credits),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_root",  32'(out_root),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_state",     32'(dbg_state), 32'd0);

    // Flush window after reset release, then first issue of 144
    rst         = 1'b0;
    in_valid    = 1'b1;
    in_radicand = 16'd144;
    ready_low   = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (in_ready !== 1'b1) ready_low++;
      tick();
    end
    #1;
    chk("flush_low_cycles", 32'(ready_low), 32'd9);
    chk("first_ready",      32'(in_ready),  32'd1);
    chk("first_start",      32'(sq_start),  32'd1);
    tick();
    in_valid = 1'b0;
    chk("credits_one", 32'(credits), 32'd1);
    k = 0;
    while (sq_data_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("pipe_latency", 32'(k), 32'd8);
    chk("pre_write_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("root144_valid", 32'(out_valid), 32'd1);
    chk("root144",       32'(out_root),  32'd12);
    out_ready = 1'b1;
    tick();
    chk("root144_popped", 32'(out_valid), 32'd0);
    chk("credits_zero_a", 32'(credits),   32'd0);

    // Back-pressure: only DEPTH issues while the output is stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx       = 0;
    for (int c = 0; c < 16; c++) begin
      in_radicand = IB'(idx * idx);
      #1;
      if (sq_start === 1'b1) idx++;
      tick();
    end
    chk("stall_issues",   32'(idx),      32'd8);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_credits",  32'(credits),  32'd8);
    repeat (10) tick();
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_radicand = IB'(idx * idx);
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_root",  32'(out_root),  32'(j));
      chk("drain_issue", 32'(sq_start),  (j == 0) ? 32'd0 : 32'd1);
      if (sq_start === 1'b1) idx++;
      tick();
    end
    in_valid = 1'b0;
    for (int r = 8; r < 15; r++) expect_root("refill", OB'(r));
    chk("refill_empty",   32'(out_valid), 32'd0);
    chk("credits_zero_b", 32'(credits),   32'd0);

    // Extremes back to back
    in_valid    = 1'b1;
    in_radicand = 16'd65535;
    #1;
    chk("max_start", 32'(sq_start), 32'd1);
    tick();
    in_radicand = 16'd0;
    #1;
    chk("zero_start", 32'(sq_start), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_root("max", 8'd255);
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_root",  32'(out_root),  32'd0);
    tick();
    chk("ext_empty",      32'(out_valid), 32'd0);
    chk("credits_zero_c", 32'(credits),   32'd0);

    // Full FIFO with simultaneous pop and write
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_radicand = IB'((20 + j) * (20 + j));
      tick();
    end
    in_valid = 1'b0;
    repeat (12) tick();
    chk("full_credits", 32'(credits),  32'd8);
    chk("full_head",    32'(out_root), 32'd20);
    force_dv   = 1'b1;
    force_root = 8'd99;
    out_ready  = 1'b1;
    tick();
    force_dv = 1'b0;
    chk("fullrw_overflow", 32'(overflow), 32'd0);
    for (int r = 21; r < 28; r++) expect_root("fullrw", OB'(r));
    expect_root("fullrw_new", 8'd99);
    chk("fullrw_empty", 32'(out_valid), 32'd0);

    // Reset with results in flight
    in_valid = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      in_radicand = IB'(j * j);
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_credits",  32'(credits),   32'd0);
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow),  32'd0);
    chk("mid_rst_state",    32'(dbg_state), 32'd0);
    rst         = 1'b0;
    in_valid    = 1'b1;
    in_radicand = 16'd9;
    ready_low   = 0;
    seen        = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (in_ready !== 1'b1) ready_low++;
      if (out_valid === 1'b1) seen++;
      tick();
    end
    #1;
    chk("reflush_low_cycles", 32'(ready_low), 32'd9);
    chk("reflush_ready",      32'(in_ready),  32'd1);
    chk("reflush_state",      32'(dbg_state), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stale_out_valid", 32'(seen), 32'd0);
    expect_root("post_flush", 8'd3);
    chk("post_flush_empty",   32'(out_valid), 32'd0);
    chk("post_flush_credits", 32'(credits),   32'd0);

    // Overflow: write into a full FIFO with the output stalled
    out_ready = 1'b0;
    force_dv  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      force_root = OB'(40 + j);
      tick();
    end
    chk("ovf_before", 32'(overflow), 32'd0);
    force_root = 8'd77;
    tick();
    force_dv = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (3) tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_head",   32'(out_root), 32'd40);
    out_ready = 1'b1;
    for (int r = 40; r < 48; r++) expect_root("ovf_drain", OB'(r));
    chk("ovf_dropped",       32'(out_valid), 32'd0);
    chk("ovf_sticky_drained", 32'(overflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_flow_ctrl.md
SQRT_FLOW_CTRL -- requirements
Module: sqrt_flow_ctrl

Interface
REQ-001 The block SHALL have parameter INPUT_BITS, default 16, radicand width.
REQ-002 The block SHALL have localparam OUTPUT_BITS, equal to INPUT_BITS/2 + INPUT_BITS%2, the root width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, result buffer entries; power of 2, >= 2.
REQ-004 The block SHALL have parameter PIPE_LATENCY, default OUTPUT_BITS+1, cycles from sq_start to sq_data_valid of the attached sqrt pipeline.
REQ-005 One clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream radicand offered.
REQ-009 in_ready  output  1  block can accept the radicand this cycle.
REQ-010 in_radicand  input  INPUT_BITS  upstream radicand.
REQ-011 sq_start  output  1  issue pulse to the sqrt pipeline.
REQ-012 sq_radicand  output  INPUT_BITS  radicand to the sqrt pipeline.
REQ-013 sq_data_valid  input  1  result strobe from the sqrt pipeline.
REQ-014 sq_root  input  OUTPUT_BITS  result from the sqrt pipeline.
REQ-015 out_valid  output  1  buffered root available.
REQ-016 out_ready  input  1  downstream accepts the root.
REQ-017 out_root  output  OUTPUT_BITS  oldest buffered root.
REQ-018 credits  output  clog2(FIFO_DEPTH)+1  count of FIFO occupancy plus in-flight issues.
REQ-019 overflow  output  1  sticky error flag.

Function
REQ-020 Accept and issue SHALL be combinational: in_ready = !flushing && credits < FIFO_DEPTH; sq_start = in_valid && in_ready; sq_radicand = in_radicand.
REQ-021 Credits SHALL be updated once per cycle: +1 on sq_start, -1 on pop (out_valid && out_ready), unchanged when both occur or neither occurs.
REQ-022 Credits SHALL never exceed FIFO_DEPTH or go below 0.
REQ-023 The FIFO SHALL write sq_root when sq_data_valid=1 and flushing=0; the root SHALL appear on out_root, with out_valid=1, in the cycle after the write when the FIFO was empty (one-cycle latency).
REQ-024 out_valid SHALL be 1 exactly when the FIFO is non-empty; out_root SHALL hold the oldest entry; results SHALL leave in issue order.
REQ-025 Simultaneous write and pop SHALL be legal at any occupancy, including full and empty-with-pending-write; occupancy is unchanged when both occur.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A write to a full FIFO without a simultaneous pop SHALL drop the data and set overflow=1 until rst.
REQ-028 The flush state machine SHALL have states FLUSH and RUN. rst SHALL force FLUSH with a down-counter loaded to PIPE_LATENCY. In FLUSH the counter decrements each cycle, sq_data_valid is ignored, and in_ready=0. When the counter reaches 0 the state SHALL move to RUN. RUN is held until the next rst.
REQ-029 The attached pipeline has no reset; results in flight at rst SHALL be discarded by FLUSH and never reach out_valid.
REQ-030 out_valid, out_root and pop SHALL be independent of in_valid; a stalled output SHALL back-pressure input only through credits.

Reset
REQ-031 On rst=1 at a clock edge: credits=0, FIFO empty, pointers=0, out_valid=0, out_root=0, overflow=0, state=FLUSH, counter=PIPE_LATENCY.
REQ-032 rst SHALL take priority over every simultaneous event, including issue, write and pop.

Verification
REQ-033 Release rst, in_valid held 1 with in_radicand=144 -> in_ready=0 for exactly 9 cycles; first sq_start in cycle 10; out_root=12 and out_valid=1 one cycle after sq_data_valid.
REQ-034 out_ready=0, continuous in_valid, radicands 0,1,4,...,49 -> exactly 8 issues, then in_ready=0 and credits=8; set out_ready=1 -> roots 0..7 in order, and one new issue per pop.
REQ-035 in_radicand=65535, then 0, back-to-back with out_ready=1 -> out_root=255 then 0 on consecutive cycles; credits return to 0.
REQ-036 FIFO full with out_ready=1 and sq_data_valid=1 in the same cycle -> occupancy stays 8; no overflow; order preserved.
REQ-037 Assert rst with 5 results in flight -> no out_valid from those results; overflow=0; credits=0; normal operation after 9 flush cycles.
REQ-038 Force sq_data_valid=1 with the FIFO full and out_ready=0 -> overflow=1 and stays 1 until rst.
